// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared states and constants for the USB transmit serializer (USB_TX_CRC16_EN adds the CRC state)
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
`ifdef USB_TX_CRC16_EN
        ST_CRC,
`endif
        ST_EOP_REQ,
        ST_EOP_WAIT,
        ST_DONE
    } tx_state_e;

    localparam logic [7:0]  SYNC_BYTE       = 8'h80;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    // Reflected CRC-16 update for one bit, LSB-first
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        return (crc >> 1) ^ ((crc[0] ^ bit_in) ? CRC16_POLY_REFL : 16'h0000);
    endfunction

endpackage

// File: rtl/usb_tx_serializer_if.sv
// rtl/usb_tx_serializer_if.sv - byte handshake, encoder strobes and status of the transmit serializer
interface usb_tx_serializer_if;
    logic       tx_start;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic       tx_hold;
    logic       transmit_eop;
    logic       tx_out_bit;
    logic       tx_shift;
    logic       create_eop;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport slave (
        input  tx_start, byte_data, byte_valid, byte_last, tx_hold, transmit_eop,
        output byte_ready, tx_out_bit, tx_shift, create_eop, tx_busy, tx_done, tx_err
    );

    modport master (
        output tx_start, byte_data, byte_valid, byte_last, tx_hold, transmit_eop,
        input  byte_ready, tx_out_bit, tx_shift, create_eop, tx_busy, tx_done, tx_err
    );
endinterface

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - bit-serial reflected CRC-16 accumulator, built only with USB_TX_CRC16_EN
`ifdef USB_TX_CRC16_EN
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        bit_in,
    output logic [15:0] crc_out
);
    logic [15:0] crc_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            crc_q <= CRC16_INIT;
        end else if (clear) begin
            crc_q <= CRC16_INIT;
        end else if (shift_en) begin
            crc_q <= crc16_step(crc_q, bit_in);
        end
    end

    assign crc_out = crc_q;
endmodule
`endif

// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - SYNC + payload byte serializer feeding the NRZI/bit-stuff encoder
// USB_TX_CRC16_EN appends the inverted CRC-16 of the non-PID payload before EOP.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    usb_tx_serializer_if.slave  bus
);
    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    shreg_q;
    logic [3:0]    idx_q;
    logic          last_q;
    logic          eop_seen_q;
    logic          out_bit_q;
    logic          create_eop_q;
    logic          tx_busy_q;
    logic          tx_done_q;
    logic          tx_err_q;

    logic shifting;
    logic shift_w;
    logic consume;
    logic need_byte;

    always_comb begin
        shifting = (state_q == ST_SYNC) || (state_q == ST_DATA);
`ifdef USB_TX_CRC16_EN
        shifting = shifting || (state_q == ST_CRC);
`endif
    end

    // A shift with tx_hold high is a stuff bit: nothing advances, the same bit is re-sent
    assign shift_w   = shifting && (cnt_q == CNT_LAST);
    assign consume   = shift_w && !bus.tx_hold;
    assign need_byte = consume && (idx_q[2:0] == 3'd7) &&
                       ((state_q == ST_SYNC) || ((state_q == ST_DATA) && !last_q));

    assign bus.byte_ready = need_byte && bus.byte_valid;
    assign bus.tx_shift   = shift_w;
    assign bus.create_eop = create_eop_q;
    assign bus.tx_busy    = tx_busy_q;
    assign bus.tx_done    = tx_done_q;
    assign bus.tx_err     = tx_err_q;

`ifdef USB_TX_CRC16_EN
    logic        pid_q;
    logic [15:0] crc_out;

    usb_crc16 u_crc (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (state_q == ST_IDLE),
        .shift_en (consume && (state_q == ST_DATA) && !pid_q),
        .bit_in   (shreg_q[0]),
        .crc_out  (crc_out)
    );

    // The CRC register is frozen during ST_CRC and indexed LSB-first
    assign bus.tx_out_bit = (state_q == ST_CRC) ? ~crc_out[idx_q] : out_bit_q;
`else
    assign bus.tx_out_bit = out_bit_q;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            idx_q        <= '0;
            last_q       <= 1'b0;
            eop_seen_q   <= 1'b0;
            out_bit_q    <= 1'b1;
            create_eop_q <= 1'b0;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_err_q     <= 1'b0;
`ifdef USB_TX_CRC16_EN
            pid_q        <= 1'b0;
`endif
        end else begin
            create_eop_q <= 1'b0;
            tx_done_q    <= 1'b0;
            tx_err_q     <= 1'b0;
            if (shifting) begin
                cnt_q <= shift_w ? '0 : cnt_q + CW'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    out_bit_q <= 1'b1;
                    if (bus.tx_start) begin
                        state_q    <= ST_SYNC;
                        shreg_q    <= SYNC_BYTE;
                        out_bit_q  <= SYNC_BYTE[0];
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        eop_seen_q <= 1'b0;
                        tx_busy_q  <= 1'b1;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    if (consume) begin
                        if (idx_q[2:0] == 3'd7) begin
                            idx_q <= '0;
                            if (need_byte) begin
                                if (bus.byte_valid) begin
                                    state_q   <= ST_DATA;
                                    shreg_q   <= bus.byte_data;
                                    out_bit_q <= bus.byte_data[0];
                                    last_q    <= bus.byte_last;
`ifdef USB_TX_CRC16_EN
                                    pid_q     <= (state_q == ST_SYNC);
`endif
                                end else begin
                                    state_q      <= ST_EOP_REQ;
                                    tx_err_q     <= 1'b1;
                                    create_eop_q <= 1'b1;
                                    out_bit_q    <= 1'b1;
                                end
                            end else begin
                                out_bit_q <= 1'b1;
`ifdef USB_TX_CRC16_EN
                                state_q   <= ST_CRC;
`else
                                state_q      <= ST_EOP_REQ;
                                create_eop_q <= 1'b1;
`endif
                            end
                        end else begin
                            shreg_q   <= {1'b0, shreg_q[7:1]};
                            out_bit_q <= shreg_q[1];
                            idx_q     <= idx_q + 4'd1;
                        end
                    end
                end
`ifdef USB_TX_CRC16_EN
                ST_CRC: begin
                    if (consume) begin
                        if (idx_q == 4'd15) begin
                            state_q      <= ST_EOP_REQ;
                            create_eop_q <= 1'b1;
                            idx_q        <= '0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
`endif
                ST_EOP_REQ: begin
                    state_q    <= ST_EOP_WAIT;
                    eop_seen_q <= bus.transmit_eop;
                end
                ST_EOP_WAIT: begin
                    if (eop_seen_q && !bus.transmit_eop) begin
                        state_q   <= ST_DONE;
                        tx_done_q <= 1'b1;
                    end else if (bus.transmit_eop) begin
                        eop_seen_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    tx_busy_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    tx_busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb/tb_usb_tx_serializer.sv - scoreboard bench for usb_tx_serializer (USB_TX_CRC16_EN adds CRC cases)
module tb_usb_tx_serializer;
    localparam int          CPB  = 8;
    localparam logic [7:0]  SYNC = 8'h80;
`ifdef USB_TX_CRC16_EN
    localparam int CRC_BITS = 16;
`else
    localparam int CRC_BITS = 0;
`endif

    logic clk = 1'b0;
    logic n_rst;
    int   passed = 0;
    int   total  = 0;
    bit   exp_q[$];

    usb_tx_serializer_if bus();

    usb_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    endtask

    function automatic logic [15:0] crc_update(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ b[i]) ? 16'hA001 : 16'h0000);
        return c;
    endfunction

    task automatic push_crc(input logic [15:0] crc);
        if (CRC_BITS != 0) begin
            for (int i = 0; i < 16; i++) exp_q.push_back(~crc[i]);
        end
    endtask

    task automatic drive_eop();
        repeat (2) tick();
        bus.transmit_eop = 1'b1;
        repeat (3) tick();
        bus.transmit_eop = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        bus.tx_start = 0; bus.byte_data = 0; bus.byte_valid = 0; bus.byte_last = 0;
        bus.tx_hold = 0; bus.transmit_eop = 0;
        n_rst = 1'b0;
        repeat (3) tick();
        n_rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if ({bus.tx_out_bit, bus.tx_shift, bus.create_eop, bus.byte_ready, bus.tx_busy, bus.tx_done, bus.tx_err} !== 7'b1000000)
                $display("FAIL reset_idle cycle %0d: got %b expected 1000000", c,
                         {bus.tx_out_bit, bus.tx_shift, bus.create_eop, bus.byte_ready, bus.tx_busy, bus.tx_done, bus.tx_err});
            else passed++;
            tick();
        end
    endtask

    task automatic test_single_byte();
        int create_c = -1, first_shift_c = -1, nshift = 0, nready = 0, ready_shift = -1;
        exp_q.delete();
        push_byte(SYNC); push_byte(8'hC3); push_crc(16'hFFFF);
        bus.byte_data = 8'hC3; bus.byte_valid = 1; bus.byte_last = 1; bus.tx_start = 1;
        for (int c = 0; c < 600 && create_c < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++;
                if ({bus.tx_out_bit, bus.tx_busy} !== 2'b01)
                    $display("FAIL single_first_bit: got out/busy %b expected 01", {bus.tx_out_bit, bus.tx_busy});
                else passed++;
            end
            if (bus.tx_shift) begin
                nshift++;
                if (first_shift_c < 0) first_shift_c = c;
                total++;
                if (exp_q.size() == 0) $display("FAIL single_bit %0d: got %b expected no bit", nshift, bus.tx_out_bit);
                else if (bus.tx_out_bit !== exp_q[0]) $display("FAIL single_bit %0d: got %b expected %b", nshift, bus.tx_out_bit, exp_q[0]);
                else passed++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (bus.byte_ready) begin
                nready++;
                ready_shift = nshift;
            end
            if (bus.create_eop) create_c = c;
            tick();
            bus.tx_start = 0;
        end
        total++; if (first_shift_c !== CPB) $display("FAIL single_first_shift: got cycle %0d expected %0d", first_shift_c, CPB); else passed++;
        total++; if (create_c !== 1 + CPB * (16 + CRC_BITS)) $display("FAIL single_create_eop: got cycle %0d expected %0d", create_c, 1 + CPB * (16 + CRC_BITS)); else passed++;
        total++; if (nready !== 1) $display("FAIL single_ready_count: got %0d expected 1", nready); else passed++;
        total++; if (ready_shift !== 8) $display("FAIL single_ready_shift: got %0d expected 8", ready_shift); else passed++;
        total++; if (nshift !== 16 + CRC_BITS) $display("FAIL single_shift_count: got %0d expected %0d", nshift, 16 + CRC_BITS); else passed++;
        for (int e = 0; e < 10; e++) begin
            if (e == 2) bus.transmit_eop = 1'b1;
            if (e == 5) bus.transmit_eop = 1'b0;
            @(negedge clk);
            total++;
            if ({bus.create_eop, bus.tx_done, bus.tx_busy} !== {1'b0, e == 6, e < 7})
                $display("FAIL single_eop cycle %0d: got create/done/busy %b expected %b", e,
                         {bus.create_eop, bus.tx_done, bus.tx_busy}, {1'b0, e == 6, e < 7});
            else passed++;
            tick();
        end
    endtask

    task automatic test_stuff_bit();
        int create_c = -1, nshift = 0, nready = 0;
        logic got_ready;
        logic [15:0] crc = 16'hFFFF;
        exp_q.delete();
        push_byte(SYNC); push_byte(8'hFF);
        bus.byte_data = 8'hFF; bus.byte_valid = 1; bus.byte_last = 0; bus.tx_hold = 0; bus.tx_start = 1;
        for (int c = 0; c < 800 && create_c < 0; c++) begin
            @(negedge clk);
            got_ready = bus.byte_ready;
            if (got_ready) nready++;
            if (bus.tx_shift) begin
                nshift++;
                total++;
                if (exp_q.size() == 0) $display("FAIL stuff_bit %0d: got %b expected no bit", nshift, bus.tx_out_bit);
                else if (bus.tx_out_bit !== exp_q[0]) $display("FAIL stuff_bit %0d: got %b expected %b", nshift, bus.tx_out_bit, exp_q[0]);
                else passed++;
                if (!bus.tx_hold && exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (bus.create_eop) create_c = c;
            tick();
            bus.tx_start = 0;
            if (got_ready && nready == 1) begin
                bus.byte_data = 8'hFF; bus.byte_last = 1;
                push_byte(8'hFF);
                crc = crc_update(crc, 8'hFF);
                push_crc(crc);
            end
            bus.tx_hold = (nshift == 14);
        end
        bus.tx_hold = 0;
        total++; if (nshift !== 25 + CRC_BITS) $display("FAIL stuff_shift_count: got %0d expected %0d", nshift, 25 + CRC_BITS); else passed++;
        total++; if (create_c !== 1 + CPB * (25 + CRC_BITS)) $display("FAIL stuff_create_eop: got cycle %0d expected %0d", create_c, 1 + CPB * (25 + CRC_BITS)); else passed++;
        total++; if (nready !== 2) $display("FAIL stuff_ready_count: got %0d expected 2", nready); else passed++;
        total++; if (exp_q.size() !== 0) $display("FAIL stuff_leftover_bits: got %0d expected 0", exp_q.size()); else passed++;
        drive_eop();
        @(negedge clk);
        total++; if (bus.tx_busy !== 1'b0) $display("FAIL stuff_idle_after: got busy %b expected 0", bus.tx_busy); else passed++;
        tick();
    endtask

    task automatic test_underrun();
        int create_c = -1, err_c = -1, nerr = 0, nready = 0, post_shifts = 0, nshift = 0;
        exp_q.delete();
        push_byte(SYNC); push_byte(8'hA5);
        bus.byte_data = 8'hA5; bus.byte_valid = 1; bus.byte_last = 0; bus.tx_start = 1;
        for (int c = 0; c < 400 && !(err_c >= 0 && c > err_c + 30); c++) begin
            @(negedge clk);
            if (bus.byte_ready) nready++;
            if (bus.tx_shift) begin
                if (err_c >= 0) post_shifts++;
                else begin
                    nshift++;
                    total++;
                    if (exp_q.size() == 0) $display("FAIL underrun_bit %0d: got %b expected no bit", nshift, bus.tx_out_bit);
                    else if (bus.tx_out_bit !== exp_q[0]) $display("FAIL underrun_bit %0d: got %b expected %b", nshift, bus.tx_out_bit, exp_q[0]);
                    else passed++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
            if (bus.tx_err) begin
                nerr++;
                if (err_c < 0) err_c = c;
            end
            if (bus.create_eop && create_c < 0) create_c = c;
            tick();
            bus.tx_start = 0;
            if (nready == 1) bus.byte_valid = 0;
        end
        total++; if (err_c !== 1 + CPB * 16) $display("FAIL underrun_err_cycle: got %0d expected %0d", err_c, 1 + CPB * 16); else passed++;
        total++; if (create_c !== 1 + CPB * 16) $display("FAIL underrun_create_eop: got %0d expected %0d", create_c, 1 + CPB * 16); else passed++;
        total++; if (nerr !== 1) $display("FAIL underrun_err_pulses: got %0d expected 1", nerr); else passed++;
        total++; if (post_shifts !== 0) $display("FAIL underrun_post_shifts: got %0d expected 0", post_shifts); else passed++;
        total++; if (exp_q.size() !== 0) $display("FAIL underrun_leftover_bits: got %0d expected 0", exp_q.size()); else passed++;
        drive_eop();
        @(negedge clk);
        total++; if (bus.tx_busy !== 1'b0) $display("FAIL underrun_idle_after: got busy %b expected 0", bus.tx_busy); else passed++;
        tick();
    endtask

`ifdef USB_TX_CRC16_EN
    task automatic test_crc();
        int create_c = -1, nshift = 0, nready = 0;
        logic got_ready;
        logic [15:0] crc = 16'hFFFF;
        exp_q.delete();
        push_byte(SYNC); push_byte(8'hC3);
        bus.byte_data = 8'hC3; bus.byte_valid = 1; bus.byte_last = 0; bus.tx_start = 1;
        for (int c = 0; c < 800 && create_c < 0; c++) begin
            @(negedge clk);
            got_ready = bus.byte_ready;
            if (got_ready) nready++;
            if (bus.tx_shift) begin
                nshift++;
                total++;
                if (exp_q.size() == 0) $display("FAIL crc_bit %0d: got %b expected no bit", nshift, bus.tx_out_bit);
                else if (bus.tx_out_bit !== exp_q[0]) $display("FAIL crc_bit %0d: got %b expected %b", nshift, bus.tx_out_bit, exp_q[0]);
                else passed++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (bus.create_eop) create_c = c;
            tick();
            bus.tx_start = 0;
            if (got_ready && nready == 1) begin
                bus.byte_data = 8'h5A; bus.byte_last = 1;
                push_byte(8'h5A);
                crc = crc_update(crc, 8'h5A);
                push_crc(crc);
            end
        end
        total++; if (create_c !== 1 + CPB * 40) $display("FAIL crc_create_eop: got cycle %0d expected %0d", create_c, 1 + CPB * 40); else passed++;
        total++; if (nshift !== 40) $display("FAIL crc_shift_count: got %0d expected 40", nshift); else passed++;
        drive_eop();
    endtask
`endif

    task automatic test_reset_mid();
        int create_c = -1, nshift = 0;
        exp_q.delete();
        bus.byte_data = 8'h5A; bus.byte_valid = 1; bus.byte_last = 1; bus.tx_start = 1;
        tick();
        bus.tx_start = 0;
        repeat (79) tick();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({bus.tx_out_bit, bus.tx_shift, bus.create_eop, bus.byte_ready, bus.tx_busy, bus.tx_done, bus.tx_err} !== 7'b1000000)
                $display("FAIL reset_mid cycle %0d: got %b expected 1000000", c,
                         {bus.tx_out_bit, bus.tx_shift, bus.create_eop, bus.byte_ready, bus.tx_busy, bus.tx_done, bus.tx_err});
            else passed++;
            tick();
        end
        push_byte(SYNC); push_byte(8'h5A); push_crc(16'hFFFF);
        bus.tx_start = 1;
        for (int c = 0; c < 600 && create_c < 0; c++) begin
            @(negedge clk);
            if (bus.tx_shift) begin
                nshift++;
                total++;
                if (exp_q.size() == 0) $display("FAIL restart_bit %0d: got %b expected no bit", nshift, bus.tx_out_bit);
                else if (bus.tx_out_bit !== exp_q[0]) $display("FAIL restart_bit %0d: got %b expected %b", nshift, bus.tx_out_bit, exp_q[0]);
                else passed++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (bus.create_eop) create_c = c;
            tick();
            bus.tx_start = 0;
        end
        total++; if (create_c !== 1 + CPB * (16 + CRC_BITS)) $display("FAIL restart_create_eop: got cycle %0d expected %0d", create_c, 1 + CPB * (16 + CRC_BITS)); else passed++;
        drive_eop();
        @(negedge clk);
        total++; if (bus.tx_busy !== 1'b0) $display("FAIL restart_idle_after: got busy %b expected 0", bus.tx_busy); else passed++;
        tick();
    endtask

    initial begin
        n_rst = 1'b0;
        test_reset();
        test_single_byte();
        test_stuff_bit();
        test_underrun();
`ifdef USB_TX_CRC16_EN
        test_crc();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
